// File: rtl/nibble_add_seq.sv
// nibble_add_seq: wide adder/subtractor built from one 4-bit CLA slice that is
// reused once per nibble, least-significant nibble first, with the carry held
// in a register between nibbles.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset
//   start  : request, only sampled while idle
//   sub    : 0 = a + b + ci, 1 = a - b (ci ignored)
//   a, b   : W-bit operands, latched on an accepted start
//   ci     : carry-in for add, latched on an accepted start
//   busy   : high while nibbles are being processed
//   done   : one-cycle pulse, result valid
//   s      : W-bit sum/difference register
//   co     : carry out of the MSB (for sub: 1 = no borrow)
//   ovf    : signed overflow of the W-bit result

// 4-bit carry-lookahead slice: generate/propagate carries plus sum XORs.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c3,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a | b;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = a ^ b ^ {c3, c2, c1, cin};

endmodule

module nibble_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 ci,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 co,
  output logic                 ovf
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept_c;
  logic             run_c;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             cr;
  logic             c3reg;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_c3;
  logic             slice_co;
  logic [W-1:0]     s_next;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE always returns to IDLE so start is ignored there.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    run_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        run_c = 1'b1;
        if (idx == IDX_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Select the current nibble of each latched operand.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        slice_a = op_a[4*n +: 4];
        slice_b = op_b[4*n +: 4];
      end
    end
  end

  cla4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (cr),
    .sum  (slice_sum),
    .c3   (slice_c3),
    .cout (slice_co)
  );

  // Merge the slice sum into its nibble of the result.
  always_comb begin
    s_next = s;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        s_next[4*n +: 4] = slice_sum;
      end
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      cr    <= 1'b0;
      c3reg <= 1'b0;
      s     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_d == ST_RUN);
      done <= (state_d == ST_DONE);
      if (accept_c) begin
        // Subtraction is a + ~b + 1.
        op_a <= a;
        op_b <= sub ? ~b : b;
        cr   <= sub | ci;
        idx  <= '0;
        s    <= '0;
      end else if (run_c) begin
        s     <= s_next;
        cr    <= slice_co;
        c3reg <= slice_c3;
        if (idx != IDX_LAST) begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Both terms are registers; after the last nibble they give the MSB carries.
  assign co  = cr;
  assign ovf = c3reg ^ cr;

endmodule

// File: tb/tb_nibble_add_seq.sv
module tb_nibble_add_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  exp_t sb_q[$];
  int   n_chk;
  int   n_pass;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xci, input logic xsub);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   r;
    bb    = xsub ? ~xb : xb;
    r     = {1'b0, xa} + {1'b0, bb} + (W+1)'(xsub ? 1'b1 : xci);
    e.s   = r[W-1:0];
    e.co  = r[W];
    e.ovf = (xa[W-1] == bb[W-1]) && (r[W-1] != xa[W-1]);
    return e;
  endfunction

  // Pop and compare whenever a done pulse is observed.
  task automatic sample_done(input string tag);
    exp_t e;
    if (done) begin
      chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({tag, "_s"}, 64'(s), 64'(e.s));
        chk({tag, "_co"}, 64'(co), 64'(e.co));
        chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
      end
    end
  endtask

  // One full operation from idle: latency, busy length and single-cycle done.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xci, input logic xsub);
    int lat;
    int busy_n;
    bit acc;
    bit seen;
    start = 1'b1; a = xa; b = xb; ci = xci; sub = xsub;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(posedge clk); #1;
      if (busy) acc = 1'b1;
    end
    chk({tag, "_accepted"}, 64'(acc), 64'd1);
    sb_q.push_back(model(xa, xb, xci, xsub));
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    lat = 0; busy_n = 1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        sample_done(tag);
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(NIBBLES));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(NIBBLES));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   acc_cyc[$];
    int   done_n;
    bit   prev_busy;
    bit   prev_done;
    bit   drained;
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    logic         cci;
    logic         csub;

    n_chk = 0; n_pass = 0;
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op("ripple_b1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("ripple_ci", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1);
    run_op("sub_big", 16'h8000, 16'h0001, 1'b0, 1'b1);
    run_op("add_rand", W'($urandom), W'($urandom), 1'b1, 1'b0);

    // Back-to-back: start held high, operands changing every cycle.
    ca = W'($urandom); cb = W'($urandom); cci = 1'($urandom); csub = 1'($urandom);
    a = ca; b = cb; ci = cci; sub = csub; start = 1'b1;
    prev_busy = busy; prev_done = done;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        sb_q.push_back(model(ca, cb, cci, csub));
        acc_cyc.push_back(cyc);
      end
      if (done) chk("hs_done_single", 64'(prev_done), 64'd0);
      sample_done("hs");
      prev_busy = busy; prev_done = done;
      ca = W'($urandom); cb = W'($urandom); cci = 1'($urandom); csub = 1'($urandom);
      a = ca; b = cb; ci = cci; sub = csub;
    end
    start = 1'b0;
    drained = (sb_q.size() == 0);
    for (int i = 0; i < 10 && !drained; i++) begin
      @(posedge clk); #1;
      if (done) chk("hs_done_single", 64'(prev_done), 64'd0);
      sample_done("hs");
      prev_done = done;
      drained = (sb_q.size() == 0);
    end
    chk("hs_drained", 64'(drained), 64'd1);
    chk("hs_accepts", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("hs_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(NIBBLES + 2));
    repeat (2) @(posedge clk);
    #1;

    // Reset sampled at the second RUN edge.
    start = 1'b1; a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    chk("mid_accepted", 64'(busy), 64'd1);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_s", 64'(s), 64'd0);
    chk("mid_rst_co", 64'(co), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) done_n++;
    end
    chk("mid_no_done", 64'(done_n), 64'd0);
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("post_rst_s_const", 64'(s), 64'h0100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
